// File: rtl/sonar_pkg.sv
// Shared types and constants for the sonar range front end.
package sonar_pkg;

  localparam int unsigned TONE_W = 16;
  localparam int unsigned PCNT_W = 17;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    DONE
  } state_t;

  function automatic int unsigned cyc_per_us(input int unsigned clk_hz);
    return clk_hz / 32'd1_000_000;
  endfunction

endpackage

// File: rtl/sonar_ranger_if.sv
// Published range word towards the tone-to-frequency decoder.
interface sonar_ranger_if;
  import sonar_pkg::*;

  logic [TONE_W-1:0] tone;
  logic              tone_valid;
  logic              timeout;

  modport master (output tone, output tone_valid, output timeout);
  modport slave  (input tone, input tone_valid, input timeout);

endinterface

// File: rtl/echo_sync.sv
// Echo pin synchronizer with registered single-cycle rise/fall pulses.
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic echo,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= echo;
      s2   <= s1;
      rise <= s1 & ~s2;
      fall <= ~s1 & s2;
    end
  end

endmodule

// File: rtl/sonar_ranger.sv
// Ultrasonic ranger: fires the sensor trigger once per period and publishes the echo width in us.
// Build option SONAR_AVG_EN: publish the average of the last four widths instead of the raw width.
module sonar_ranger
  import sonar_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned TRIG_US         = 10,
  parameter int unsigned PERIOD_US       = 60000,
  parameter int unsigned RISE_TIMEOUT_US = 5000,
  parameter int unsigned MAX_US          = 38000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           echo,
  output logic           trig,
  sonar_ranger_if.master tone_bus
);

  localparam int unsigned CYC   = cyc_per_us(CLK_HZ);
  localparam int unsigned PRE_W = (CYC > 1) ? $clog2(CYC) : 1;

  state_t              state;
  logic [PRE_W-1:0]    presc;
  logic [PRE_W-1:0]    pprsc;
  logic [PCNT_W-1:0]   pcnt;
  logic [TONE_W-1:0]   cnt;
  logic [TONE_W-1:0]   tone;
  logic                tone_valid;
  logic                timeout;
  logic                rise;
  logic                fall;

  logic                tick_c;
  logic                ptick_c;
  logic                period_hit_c;
  logic                publish_c;
  logic                pub_sat_c;
  logic [TONE_W-1:0]   width_next_c;
  logic [TONE_W-1:0]   pub_tone_c;

  echo_sync u_echo_sync (
    .clk  (clk),
    .rst  (rst),
    .echo (echo),
    .rise (rise),
    .fall (fall)
  );

  // Width prescaler realigns to the echo edge; the period one never does, keeping trigger spacing exact.
  always_comb begin
    tick_c       = (presc == PRE_W'(CYC - 1));
    ptick_c      = (pprsc == PRE_W'(CYC - 1));
    period_hit_c = (pcnt >= PCNT_W'(PERIOD_US)) ||
                   (ptick_c && (pcnt == PCNT_W'(PERIOD_US - 1)));
    width_next_c = cnt + TONE_W'(tick_c);
    publish_c    = 1'b0;
    pub_sat_c    = 1'b0;
    if (state == MEASURE) begin
      if (fall) begin
        publish_c = 1'b1;
      end else if (width_next_c == TONE_W'(MAX_US)) begin
        publish_c = 1'b1;
        pub_sat_c = 1'b1;
      end
    end
  end

`ifdef SONAR_AVG_EN
  localparam int unsigned SUM_W = TONE_W + 2;

  logic [TONE_W-1:0] hist0;
  logic [TONE_W-1:0] hist1;
  logic [TONE_W-1:0] hist2;
  logic              hist_ok;
  logic [SUM_W-1:0]  sum_c;

  // First publish after reset seeds the whole history with that sample.
  always_comb begin
    if (hist_ok) begin
      sum_c = SUM_W'(width_next_c) + SUM_W'(hist0) + SUM_W'(hist1) + SUM_W'(hist2);
    end else begin
      sum_c = {width_next_c, 2'b00};
    end
    pub_tone_c = sum_c[SUM_W-1:2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist0   <= '0;
      hist1   <= '0;
      hist2   <= '0;
      hist_ok <= 1'b0;
    end else if (publish_c) begin
      hist_ok <= 1'b1;
      hist0   <= width_next_c;
      hist1   <= hist_ok ? hist0 : width_next_c;
      hist2   <= hist_ok ? hist1 : width_next_c;
    end
  end
`else
  assign pub_tone_c = width_next_c;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      trig       <= 1'b0;
      tone       <= '0;
      tone_valid <= 1'b0;
      timeout    <= 1'b0;
      cnt        <= '0;
      presc      <= '0;
      pprsc      <= '0;
      pcnt       <= PCNT_W'(PERIOD_US);
    end else begin
      tone_valid <= 1'b0;
      presc      <= tick_c ? '0 : presc + PRE_W'(1);
      pprsc      <= ptick_c ? '0 : pprsc + PRE_W'(1);
      if (ptick_c && (pcnt < PCNT_W'(PERIOD_US))) begin
        pcnt <= pcnt + PCNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (period_hit_c) begin
            state <= TRIG;
            trig  <= 1'b1;
            cnt   <= '0;
            presc <= '0;
            pprsc <= '0;
            pcnt  <= '0;
          end
        end
        TRIG: begin
          if (tick_c) begin
            if (cnt == TONE_W'(TRIG_US - 1)) begin
              state <= WAIT_RISE;
              trig  <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + TONE_W'(1);
            end
          end
        end
        WAIT_RISE: begin
          // A rise on the final timeout tick still wins.
          if (rise) begin
            state <= MEASURE;
            cnt   <= '0;
            presc <= '0;
          end else if (tick_c) begin
            if (cnt == TONE_W'(RISE_TIMEOUT_US - 1)) begin
              state   <= IDLE;
              timeout <= 1'b1;
            end else begin
              cnt <= cnt + TONE_W'(1);
            end
          end
        end
        MEASURE: begin
          if (publish_c) begin
            state      <= DONE;
            tone       <= pub_tone_c;
            tone_valid <= 1'b1;
            timeout    <= pub_sat_c;
          end else begin
            cnt <= width_next_c;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign tone_bus.tone       = tone;
  assign tone_bus.tone_valid = tone_valid;
  assign tone_bus.timeout    = timeout;

endmodule

// File: doc/sonar_ranger.md
# sonar_ranger

Ultrasonic range front end for the theremin: drives the HC-SR04-style trigger, measures the echo pulse width in microseconds and publishes it as the 16-bit `tone` word consumed by the tone-to-frequency decoder. It is the producer side of the `tone` interface. It sits between the sensor pins and the decoder, with one measurement per fixed period.

## Interface
- `CLK_HZ`, 100_000_000: clock frequency. `CYC_PER_US = CLK_HZ/1_000_000`, which must be at least 1.
- `TRIG_US`, 10: trigger pulse width in µs.
- `PERIOD_US`, 60000: trigger-to-trigger period in µs.
- `RISE_TIMEOUT_US`, 5000: maximum wait, from trig fall to echo rise.
- `MAX_US`, 38000: echo width saturation value. Must be at most 65535.
- Constraint: `PERIOD_US > TRIG_US + RISE_TIMEOUT_US + MAX_US + 2`.
- `clk`  in  1  system clock. One clock domain.
- `rst`  in  1  reset. Synchronous and active-high.
- `echo`  in  1  sensor echo. Asynchronous to `clk`.
- `trig`  out  1  sensor trigger.
- `tone`  out  16  last published echo width in µs.
- `tone_valid`  out  1  one-cycle pulse when `tone` updates.
- `timeout`  out  1  level. Set to 1 when the last cycle failed or saturated.

## Operation
- `echo` passes through a 2-flop synchronizer and a rising/falling edge detector. Only edges count; a level already high on entering WAIT_RISE is ignored.
- A µs prescaler counts `CYC_PER_US` cycles and emits a tick. It restarts on entry to TRIG and on the echo rising edge.
- A period counter in µs restarts at every TRIG entry.
- FSM states:
  - IDLE: wait for the period counter to reach `PERIOD_US`, then go to TRIG.
  - TRIG: `trig`=1 for `TRIG_US` ticks, then go to WAIT_RISE.
  - WAIT_RISE: `trig`=0.
    - On a rising edge, clear the width counter and go to MEASURE.
    - After `RISE_TIMEOUT_US` ticks without a rising edge, set `timeout`=1, leave `tone` unchanged, give no `tone_valid`, and go to IDLE.
  - MEASURE: increment the width counter per tick.
    - On a falling edge, go to DONE.
    - If the counter reaches `MAX_US` while echo is still high, also go to DONE with the saturated flag set.
  - DONE: for exactly 1 cycle.
    - Load `tone` with the width and pulse `tone_valid`.
    - Set `timeout`=1 if saturated, else `timeout`=0.
    - Go to IDLE.
- Width = floor(high-time cycles / `CYC_PER_US`), clamped to `MAX_US`. Width counter is 16 bits; period counter is 17 bits.
- Reset values: `trig`=0, `tone`=0, `tone_valid`=0, `timeout`=0, synchronizer=0. The state is IDLE with the period counter preloaded to expired, so the first trigger starts immediately after reset.
- `rst` mid-operation (any state) aborts the measurement with no `tone_valid`. `trig` drops on the same edge.

## Timing
- First `trig` rise occurs on the first clock edge with `rst` low. `trig` is visible 1 cycle after `rst` deasserts.
- `trig` high time is exactly `TRIG_US*CYC_PER_US` cycles.
- Rising edges of `trig` are spaced exactly `PERIOD_US*CYC_PER_US` cycles apart.
- `tone_valid` asserts 3 cycles after the echo pin falls (2 sync + 1 DONE). `tone` and `timeout` update on that same cycle.
- A rise timeout sets `timeout` on the cycle of the `RISE_TIMEOUT_US`-th tick after trig falls.
- `tone_valid` never asserts twice within one period.

## Configuration
- `SONAR_AVG_EN` defined: keeps a 4-entry history of published widths, including saturated ones.
  - `tone` = (sum of the new width and the 3 previous entries) >> 2, using an 18-bit sum, truncated.
  - On the first publish after reset, all 4 entries load with that sample.
  - Latency is unchanged.
- `SONAR_AVG_EN` undefined: `tone` = raw width.

## Structure
- Package `sonar_pkg`:
  - FSM state enum (IDLE, TRIG, WAIT_RISE, MEASURE, DONE)
  - the `tone` width constant (16)
  - the `CYC_PER_US` derivation function
- Sub-module `echo_sync`: 2-flop synchronizer plus registered rise/fall pulses, using `clk` and `rst`.

## Test plan
All scenarios use `CLK_HZ`=1_000_000, `PERIOD_US`=2000, `RISE_TIMEOUT_US`=200, `MAX_US`=1000.
- Reset released → `trig` high for exactly 10 cycles starting 1 cycle later. `tone`=0, `tone_valid`=0, `timeout`=0 throughout reset.
- Echo high for 580 cycles, 50 cycles after trig fall → `tone`=580, a single `tone_valid` pulse 3 cycles after echo falls, `timeout`=0.
- No echo → `timeout`=1 exactly 200 cycles after trig fall. `tone` holds 580, there is no `tone_valid`, and the next `trig` rise comes 2000 cycles after the previous one.
- Echo held high for 1500 cycles → `tone`=1000, `tone_valid` pulses, `timeout`=1. Echo already high on the next WAIT_RISE → ignored until it falls and rises again.
- `rst` pulsed mid-MEASURE (width 300 so far) → outputs return to their reset values with no `tone_valid`, and `trig` restarts 1 cycle after release.
- `SONAR_AVG_EN`: widths 400, 400, 400, 800 → `tone` = 400, 400, 400, 500.
